key_press_gen: RTL and testbench

Per-channel press generator: turns single-cycle request pulses on four channels into active-low key levels held for a fixed number of cycles, then released for a guaranteed gap. It is the level-producing counterpart of the key edge detector: its `key_n` outputs use the same "0 = pressed, 1 = released" convention as the board keys. Game logic or a test sequencer uses it to emulate button presses into any block that consumes key levels. Each channel runs an independent state machine with one pending-request slot.

---
 rtl/key_press_gen.sv | 132 +++++++++++++
 tb/tb_key_press_gen.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/key_press_gen.sv
// Four-channel press generator: request pulses become active-low key levels held
// for HOLD_CYCLES, followed by a release gap of at least GAP_CYCLES.
// Optional KEY_PRESS_GEN_RETRIGGER_EN: a pulse during HOLD restarts the hold time
// instead of queueing a second press.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | key released, channel free, counter parked at 0
// ST_HOLD | key pressed (key_n=0), counting down the hold time
// ST_GAP  | key released, counting down the mandatory release gap

module key_press_gen #(
    parameter int HOLD_CYCLES = 1000,
    parameter int GAP_CYCLES  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] pulse_in,
    output logic [3:0] key_n,
    output logic [3:0] busy
);

    localparam int MAX_CYCLES = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t           state_q [4];
    state_t           state_d [4];
    logic [CNT_W-1:0] cnt_q   [4];
    logic [CNT_W-1:0] cnt_d   [4];
    logic [3:0]       pend_q, pend_d;
    logic [3:0]       key_n_q, key_n_d;
    logic [3:0]       busy_q, busy_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= CNT_ZERO;
            end
            pend_q  <= 4'h0;
            key_n_q <= 4'hF;
            busy_q  <= 4'h0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            pend_q  <= pend_d;
            key_n_q <= key_n_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        pend_d  = pend_q;
        key_n_d = 4'hF;
        busy_d  = 4'h0;
        for (int i = 0; i < 4; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                ST_IDLE: begin
                    if (pulse_in[i]) begin
                        state_d[i] = ST_HOLD;
                        cnt_d[i]   = HOLD_LOAD;
                    end
                end
                ST_HOLD: begin
`ifdef KEY_PRESS_GEN_RETRIGGER_EN
                    if (pulse_in[i]) begin
                        cnt_d[i] = HOLD_LOAD;
                    end else if (cnt_q[i] == CNT_ZERO) begin
                        state_d[i] = ST_GAP;
                        cnt_d[i]   = GAP_LOAD;
                    end else begin
                        cnt_d[i] = cnt_q[i] - CNT_ONE;
                    end
`else
                    if (pulse_in[i]) begin
                        pend_d[i] = 1'b1;
                    end
                    if (cnt_q[i] == CNT_ZERO) begin
                        state_d[i] = ST_GAP;
                        cnt_d[i]   = GAP_LOAD;
                    end else begin
                        cnt_d[i] = cnt_q[i] - CNT_ONE;
                    end
`endif
                end
                ST_GAP: begin
                    if (cnt_q[i] == CNT_ZERO) begin
                        // a pulse on the final gap edge starts the next press directly
                        if (pend_q[i] || pulse_in[i]) begin
                            state_d[i] = ST_HOLD;
                            cnt_d[i]   = HOLD_LOAD;
                            pend_d[i]  = 1'b0;
                        end else begin
                            state_d[i] = ST_IDLE;
                        end
                    end else begin
                        cnt_d[i] = cnt_q[i] - CNT_ONE;
                        if (pulse_in[i]) begin
                            pend_d[i] = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d[i] = ST_IDLE;
                    cnt_d[i]   = CNT_ZERO;
                    pend_d[i]  = 1'b0;
                end
            endcase
            key_n_d[i] = (state_d[i] != ST_HOLD);
            busy_d[i]  = (state_d[i] != ST_IDLE);
        end
    end

    assign key_n = key_n_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_key_press_gen.sv
// Scoreboard bench for key_press_gen (HOLD_CYCLES=4, GAP_CYCLES=2): a timeline
// model of each channel's press window predicts the outputs after every edge.

module tb_key_press_gen;

    localparam int H = 4;
    localparam int G = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] pulse_in = 4'h0;
    logic [3:0] key_n;
    logic [3:0] busy;

    key_press_gen #(.HOLD_CYCLES(H), .GAP_CYCLES(G)) dut (
        .clk      (clk),
        .reset    (reset),
        .pulse_in (pulse_in),
        .key_n    (key_n),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int t = 0;

    // Model: edge index at which the current press started determines the window.
    // hold_end = last edge spent in HOLD, gap_end = last edge spent in GAP.
    int hold_end [4];
    int gap_end  [4];
    bit pend     [4];

    logic [7:0] exp_q [$];
    logic [7:0] got_e;

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            hold_end[c] = -1;
            gap_end[c]  = -1;
            pend[c]     = 1'b0;
        end
    endtask

    task automatic start_press(input int c);
        hold_end[c] = t + H;
        gap_end[c]  = t + H + G;
        pend[c]     = 1'b0;
    endtask

    task automatic step(input logic [3:0] p);
        logic [3:0] ek;
        logic [3:0] eb;
        @(negedge clk);
        pulse_in = p;
        t++;
        for (int c = 0; c < 4; c++) begin
            if (t <= hold_end[c]) begin
`ifdef KEY_PRESS_GEN_RETRIGGER_EN
                if (p[c]) start_press(c);
`else
                if (p[c]) pend[c] = 1'b1;
`endif
            end else if (t <= gap_end[c]) begin
                if (t == gap_end[c]) begin
                    if (pend[c] || p[c]) start_press(c);
                end else if (p[c]) begin
                    pend[c] = 1'b1;
                end
            end else if (p[c]) begin
                start_press(c);
            end
            ek[c] = !(t < hold_end[c]);
            eb[c] = (t < gap_end[c]);
        end
        exp_q.push_back({ek, eb});
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(4'h0);
    endtask

    task automatic check_reset_vals(input string name);
        checks++;
        if (key_n !== 4'hF || busy !== 4'h0) begin
            errors++;
            $display("FAIL %s key_n=%b busy=%b expected key_n=1111 busy=0000", name, key_n, busy);
        end
    endtask

    // Assert reset mid-cycle and check outputs change without a clock edge.
    task automatic async_reset(input string name);
        @(negedge clk);
        pulse_in = 4'h0;
        #2 reset = 1'b1;
        #1 check_reset_vals(name);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            got_e = exp_q.pop_front();
            checks++;
            if ({key_n, busy} !== got_e) begin
                errors++;
                $display("FAIL outputs t=%0d key_n=%b busy=%b expected key_n=%b busy=%b",
                         t, key_n, busy, got_e[7:4], got_e[3:0]);
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_vals("power_on_reset");
        reset = 1'b0;

        idle(20);

        step(4'b0001);
        idle(10);

        step(4'b0010);
        step(4'b0000);
        step(4'b0010);
        idle(14);

        step(4'b0100);
        step(4'b0000);
        step(4'b0100);
        step(4'b0000);
        step(4'b0000);
        step(4'b0100);
        step(4'b0100);
        idle(14);

        step(4'b1111);
        idle(5);
        step(4'b1000);
        idle(10);

        step(4'b0001);
        step(4'b0000);
        step(4'b0001);
        async_reset("reset_mid_hold");
        idle(3);
        step(4'b0001);
        idle(12);

        async_reset("reset_before_random");
        for (int k = 0; k < 600; k++) begin
            logic [3:0] p;
            for (int c = 0; c < 4; c++) p[c] = ($urandom_range(0, 5) == 0);
            step(p);
            if (k == 300) async_reset("reset_random_run");
        end
        idle(12);

        @(negedge clk);
        pulse_in = 4'h0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
